// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed seven-segment scan controller (optional blink: DISPLAY_BLINK_EN)
module display_scan_controller #(
`ifdef DISPLAY_BLINK_EN
   parameter int BLINK_FRAMES = 64,
`endif
   parameter int NUM_DIGITS   = 4,
   parameter int TICK_DIV     = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    lzb,
`ifdef DISPLAY_BLINK_EN
   input  logic                    blink,
`endif
   output logic [3:0]              digit_out,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_done,
   output logic                    update_ack
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PH_LAST       = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PH_BLANK_LAST = PW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {BLANK, SHOW} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           phase_q, phase_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    wrap;

   logic [4*NUM_DIGITS-1:0] active_q, pending_q;
   logic                    pending_valid_q;
   logic                    commit_pt;

   logic [3:0]              sel_digit;
   logic                    blank_lz;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   anode_d;
   logic [3:0]              digit_d;

`ifdef DISPLAY_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   logic [BW-1:0]           blink_cnt_q;
   logic                    blink_on_q;
`endif

   // Scan state register: phase counter, digit index and BLANK/SHOW state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BLANK;
         phase_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic; a disabled scan parks at digit 0 in BLANK
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      wrap    = 1'b0;
      if (!enable) begin
         state_d = BLANK;
         phase_d = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            BLANK: begin
               phase_d = phase_q + PW'(1);
               if (phase_q == PH_BLANK_LAST) state_d = SHOW;
            end
            SHOW: begin
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  state_d = BLANK;
                  wrap    = (idx_q == IDX_LAST);
                  idx_d   = wrap ? '0 : idx_q + IW'(1);
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            default: state_d = BLANK;
         endcase
      end
   end

   // Frame boundaries and every disabled cycle are safe points to swap the displayed value
   assign commit_pt = wrap | ~enable;

   // Double buffer: loads land in pending and move to active only at a commit point
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q        <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         frame_done      <= 1'b0;
         update_ack      <= 1'b0;
      end else begin
         frame_done <= wrap;
         update_ack <= 1'b0;
         if (commit_pt && load) begin
            active_q        <= digits_in;
            pending_valid_q <= 1'b0;
            update_ack      <= 1'b1;
         end else if (commit_pt && pending_valid_q) begin
            active_q        <= pending_q;
            pending_valid_q <= 1'b0;
            update_ack      <= 1'b1;
         end else if (load) begin
            pending_q       <= digits_in;
            pending_valid_q <= 1'b1;
         end
      end
   end

   // Select the current digit and decide whether it is a suppressed leading zero
   always_comb begin
      sel_digit = 4'hF;
      blank_lz  = 1'b0;
      zero_run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run & (active_q[4*i +: 4] == 4'd0);
         if (idx_q == IW'(i)) blank_lz = lzb & zero_run;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) sel_digit = active_q[4*i +: 4];
      end
   end

`ifdef DISPLAY_BLINK_EN
   // Blink phase toggles every BLINK_FRAMES frames; blink low holds it on
   always_ff @(posedge clk) begin
      if (reset || !blink) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (wrap) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
         end
      end
   end
`endif

   // Output decode: anode active-low only in SHOW for a visible digit; codes above 9 blank the decoder
   always_comb begin
      anode_d = '1;
      digit_d = 4'hF;
      if (enable && state_q == SHOW && !blank_lz) begin
         anode_d = ~(NUM_DIGITS'(1) << idx_q);
         digit_d = (sel_digit > 4'd9) ? 4'hF : sel_digit;
      end
`ifdef DISPLAY_BLINK_EN
      if (blink && !blink_on_q) anode_d = '1;
`endif
   end

   // Registered outputs keep the panel drivers glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         anode     <= '1;
         digit_out <= 4'hF;
      end else begin
         anode     <= anode_d;
         digit_out <= digit_d;
      end
   end

endmodule
